recorder_core: RTL
==================

# recorder_core

Parametrised record/playback engine for the voice recorder. It replaces the fixed two-slot controller and address counter with one block that supports NUM_CH memory slots. It tracks a recorded length per slot and plays back exactly that length, once or looped. It sits between the synchronised button logic, the PDM deserializer, the PWM serializer and the single-port sample RAM.

## Interface
Parameters:
- NUM_CH, 2: number of recording slots (≥1)
- CH_DEPTH, 65536: samples per slot; NUM_CH*CH_DEPTH ≤ 2**ADDR_W
- ADDR_W, 17: RAM address width
- SAMPLE_W, 16: sample width
- LOOP, 0: 1 = playback wraps to sample 0 until stopped

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; one clock, no other clock domains
- rec_req  in  1  one-cycle pulse, start recording on chn_sel
- ply_req  in  1  one-cycle pulse, start playback of chn_sel
- stop_req  in  1  one-cycle pulse, end current operation
- chn_sel  in  CH_W  slot select, CH_W = max(1,$clog2(NUM_CH)); values ≥ NUM_CH ignored
- des_valid  in  1  deserializer sample strobe
- des_data  in  SAMPLE_W  deserialized sample
- des_en  out  1  deserializer enable
- ser_ready  in  1  serializer requests next sample
- ser_en  out  1  serializer enable
- ser_valid  out  1  one-cycle pulse, ser_data updated
- ser_data  out  SAMPLE_W  playback sample, held between pulses
- ram_en, ram_we  out  1  RAM strobes
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  SAMPLE_W  write data
- ram_rdata  in  SAMPLE_W  read data, valid one cycle after ram_en
- state  out  2  00 IDLE, 01 REC, 10 PLAY, 11 FETCH
- active_ch  out  CH_W  slot in use (last used when IDLE)
- done  out  1  one-cycle pulse when any operation ends

## Operation
- Reset values: state IDLE, active_ch 0. All enables, strobes, done and ser_valid are 0. ser_data, ram_addr and ram_wdata are 0. All slot lengths are 0.
- IDLE behaviour:
  - rec_req with a valid chn_sel → REC, ptr=0.
  - ply_req → PLAY, ptr=0, but only if len[chn_sel] > 0. Otherwise stay IDLE with no done pulse.
  - rec_req and ply_req in the same cycle: rec wins.
- REC:
  - des_en=1.
  - Each des_valid writes des_data to address chn*CH_DEPTH+ptr, then ptr++.
  - Exit to IDLE on stop_req, or after the write with ptr = CH_DEPTH-1 (slot full).
  - On exit, len[ch] = number of samples written (full → CH_DEPTH); done pulses.
  - stop_req coinciding with des_valid: the sample is written and counted.
  - A zero-sample record sets len to 0.
- PLAY:
  - ser_en=1. ser_ready → issue read at base+ptr, go to FETCH.
  - FETCH: capture ram_rdata into ser_data, pulse ser_valid, ptr++.
  - After sample len-1: if LOOP=0 → IDLE with done; if LOOP=1 → ptr=0, stay in PLAY.
  - ser_ready during FETCH is ignored.
- stop_req in PLAY or FETCH: a FETCH already in flight completes its ser_valid, then the block goes IDLE with done.
- rec_req and ply_req while not IDLE are ignored. chn_sel is sampled only at start.
- Reset mid-operation aborts immediately. Lengths clear; RAM contents are not erased but are unreachable.

## Timing
- Request at edge t → state and enables updated at t+1.
- des_valid at t → ram_en=ram_we=1 with addr/data for exactly cycle t+1. Sustained des_valid every cycle is supported.
- ser_ready at t in PLAY → ram_en=1, ram_we=0, addr at t+1. rdata is valid at t+2; ser_valid and new ser_data appear at t+3. Minimum of 3 cycles per sample.
- done is asserted in the first IDLE cycle.
- Address arithmetic is unsigned, ADDR_W wide; base = ch*CH_DEPTH is computed from constants and must not overflow.

## Structure
- Package recorder_pkg holds:
  - the state_t enum (IDLE, REC, PLAY, FETCH) with the fixed encodings above;
  - the CH_W and LEN_W = $clog2(CH_DEPTH+1) helper functions.
- Sub-module rec_len_table: NUM_CH × LEN_W register file with one write port, one read port, combinational read, and asynchronous clear.
- Top level contains the FSM, ptr counter and RAM/serializer output registers.

## Test plan
- Record slot 0 (NUM_CH=2, CH_DEPTH=8), 5 des_valid with data 1..5, then stop → writes to addr 0..4; len[0]=5; done pulses once.
- Record slot 1 with 10 strobes → 8 writes to addr 8..15; auto-exit after the 8th; len[1]=8; 2 strobes ignored.
- Play slot 0 with ser_ready every 4 cycles, LOOP=0 → ser_data sequence 1,2,3,4,5, each ser_valid 3 cycles after ser_ready; then done, IDLE.
- LOOP=1, play slot 0 for 12 requests → 1..5,1..5,1,2; stop → IDLE.
- ply_req on an empty slot → state stays IDLE, no ram_en, no done. rec_req+ply_req together → REC.
- Reset asserted mid-REC after 3 writes → outputs at reset values within the same cycle; subsequent ply_req on that slot is ignored (len=0).

Source files
------------

// File: rtl/recorder_pkg.sv
// Shared types and width helpers for the record/playback engine.
package recorder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REC   = 2'b01,
    PLAY  = 2'b10,
    FETCH = 2'b11
  } state_t;

  // Slot-select width; a single slot still needs one bit of port.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Length width; must hold CH_DEPTH itself for a full slot.
  function automatic int len_w(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/rec_len_table.sv
// Per-slot recorded-length register file: one write port, combinational read.
module rec_len_table #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1,
  parameter int LEN_W  = 17
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_we,
  input  logic [CH_W-1:0]  i_waddr,
  input  logic [LEN_W-1:0] i_wdata,
  input  logic [CH_W-1:0]  i_raddr,
  output logic [LEN_W-1:0] o_rdata
);

  logic [LEN_W-1:0] r_len [NUM_CH];

  // Lengths clear on reset; out-of-range slots are never written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) r_len[i] <= '0;
    end else if (i_we && (int'(i_waddr) < NUM_CH)) begin
      r_len[i_waddr] <= i_wdata;
    end
  end

  // Out-of-range slots read as empty.
  assign o_rdata = (int'(i_raddr) < NUM_CH) ? r_len[i_raddr] : '0;

endmodule

// File: rtl/recorder_core.sv
// Multi-slot record/playback engine between button logic, PDM/PWM and sample RAM.
module recorder_core
  import recorder_pkg::*;
#(
  parameter  int NUM_CH   = 2,
  parameter  int CH_DEPTH = 65536,
  parameter  int ADDR_W   = 17,
  parameter  int SAMPLE_W = 16,
  parameter  int LOOP     = 0,
  localparam int CH_W     = ch_w(NUM_CH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rec_req,
  input  logic                ply_req,
  input  logic                stop_req,
  input  logic [CH_W-1:0]     chn_sel,
  input  logic                des_valid,
  input  logic [SAMPLE_W-1:0] des_data,
  output logic                des_en,
  input  logic                ser_ready,
  output logic                ser_en,
  output logic                ser_valid,
  output logic [SAMPLE_W-1:0] ser_data,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [SAMPLE_W-1:0] ram_wdata,
  input  logic [SAMPLE_W-1:0] ram_rdata,
  output logic [1:0]          state,
  output logic [CH_W-1:0]     active_ch,
  output logic                done
);

  localparam int               LEN_W    = len_w(CH_DEPTH);
  localparam logic [LEN_W-1:0] LAST_PTR = LEN_W'(CH_DEPTH - 1);

  state_t              r_state, w_state_nxt;
  logic [LEN_W-1:0]    r_ptr, w_ptr_nxt, w_ptr_inc, w_len_rd, w_len_wdata;
  logic [CH_W-1:0]     r_ch, w_ch_nxt, w_len_raddr;
  logic                r_done, w_done_nxt;
  logic                r_ram_en, w_ram_en_nxt, r_ram_we, w_ram_we_nxt;
  logic                r_ser_valid, w_ser_valid_nxt;
  logic                r_rvld, r_stop_pend, w_stop_nxt;
  logic                w_len_we, w_sel_ok;
  logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr_nxt, w_addr;
  logic [SAMPLE_W-1:0] r_ram_wdata, w_ram_wdata_nxt, r_ser_data, w_ser_data_nxt;

  assign w_sel_ok    = (int'(chn_sel) < NUM_CH);
  assign w_ptr_inc   = r_ptr + LEN_W'(1);
  assign w_addr      = ADDR_W'(r_ch) * ADDR_W'(CH_DEPTH) + ADDR_W'(r_ptr);
  // IDLE looks up the requested slot; otherwise the slot in use.
  assign w_len_raddr = (r_state == IDLE) ? chn_sel : r_ch;

  rec_len_table #(
    .NUM_CH(NUM_CH),
    .CH_W  (CH_W),
    .LEN_W (LEN_W)
  ) u_len (
    .clock  (clock),
    .reset  (reset),
    .i_we   (w_len_we),
    .i_waddr(r_ch),
    .i_wdata(w_len_wdata),
    .i_raddr(w_len_raddr),
    .o_rdata(w_len_rd)
  );

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_ch_nxt        = r_ch;
    w_done_nxt      = 1'b0;
    w_ram_en_nxt    = 1'b0;
    w_ram_we_nxt    = 1'b0;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_wdata_nxt = r_ram_wdata;
    w_ser_valid_nxt = 1'b0;
    w_ser_data_nxt  = r_ser_data;
    w_stop_nxt      = r_stop_pend;
    w_len_we        = 1'b0;
    w_len_wdata     = '0;
    unique case (r_state)
      IDLE: begin
        w_stop_nxt = 1'b0;
        if (rec_req && w_sel_ok) begin
          w_state_nxt = REC;
          w_ptr_nxt   = '0;
          w_ch_nxt    = chn_sel;
        end else if (ply_req && w_sel_ok && (w_len_rd != '0)) begin
          w_state_nxt = PLAY;
          w_ptr_nxt   = '0;
          w_ch_nxt    = chn_sel;
        end
      end
      REC: begin
        if (des_valid) begin
          w_ram_en_nxt    = 1'b1;
          w_ram_we_nxt    = 1'b1;
          w_ram_addr_nxt  = w_addr;
          w_ram_wdata_nxt = des_data;
          w_ptr_nxt       = w_ptr_inc;
        end
        // A sample arriving with stop is still kept.
        if (stop_req || (des_valid && (r_ptr == LAST_PTR))) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
          w_len_we    = 1'b1;
          w_len_wdata = des_valid ? w_ptr_inc : r_ptr;
        end
      end
      PLAY: begin
        if (stop_req) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else if (ser_ready) begin
          w_ram_en_nxt   = 1'b1;
          w_ram_addr_nxt = w_addr;
          w_state_nxt    = FETCH;
        end
      end
      FETCH: begin
        // Stop is deferred until the read in flight is delivered.
        if (stop_req) w_stop_nxt = 1'b1;
        if (r_rvld) begin
          w_ser_valid_nxt = 1'b1;
          w_ser_data_nxt  = ram_rdata;
          w_ptr_nxt       = w_ptr_inc;
          if (stop_req || r_stop_pend) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else if (w_ptr_inc == w_len_rd) begin
            if (LOOP != 0) begin
              w_ptr_nxt   = '0;
              w_state_nxt = PLAY;
            end else begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_state_nxt = PLAY;
          end
        end
      end
    endcase
  end

  // State, pointer and output registers; reset aborts any operation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_ch        <= '0;
      r_done      <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ser_valid <= 1'b0;
      r_ser_data  <= '0;
      r_rvld      <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_ch        <= w_ch_nxt;
      r_done      <= w_done_nxt;
      r_ram_en    <= w_ram_en_nxt;
      r_ram_we    <= w_ram_we_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_ser_valid <= w_ser_valid_nxt;
      r_ser_data  <= w_ser_data_nxt;
      // RAM read data is valid the cycle after a read strobe.
      r_rvld      <= r_ram_en & ~r_ram_we;
      r_stop_pend <= w_stop_nxt;
    end
  end

  assign state     = r_state;
  assign active_ch = r_ch;
  assign done      = r_done;
  assign des_en    = (r_state == REC);
  assign ser_en    = (r_state == PLAY) || (r_state == FETCH);
  assign ser_valid = r_ser_valid;
  assign ser_data  = r_ser_data;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

endmodule
